// File: rtl/sr_ff_driver.sv
// Command-side driver for an external SR flip-flop. Target bits are queued
// in a small FIFO; each target becomes a one-sided set or reset pulse, then
// the flop's Q feedback is watched until it matches or a timeout raises a
// sticky error. s and r are never asserted together.
//
// Handshake: a target is accepted on any rising edge where in_valid and
// in_ready are both high; in_ready depends only on level, never on in_valid.
module sr_ff_driver #(
    parameter int DEPTH     = 4,
    parameter int PULSE_CYC = 1,
    parameter int TIMEOUT   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_bit,
    output logic                     in_ready,
    input  logic                     q_fb,
    input  logic                     clr_err,
    output logic                     s,
    output logic                     r,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(PULSE_CYC) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t          state, state_n;
    logic            mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic            push, pop, head;
    logic            tgt, tgt_n;
    logic [PW-1:0]   pcnt, pcnt_n;
    logic [TW-1:0]   ccnt, ccnt_n;
    logic            s_n, r_n, done_n, err_n;

    // Full is decided from the registered level only, so a same-cycle pop
    // never opens a slot for the incoming bit.
    assign in_ready = (level != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rptr];

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_bit;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Next-state, pop decision and next values of the registered outputs.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tgt_n   = tgt;
        pcnt_n  = pcnt;
        ccnt_n  = ccnt;
        s_n     = 1'b0;
        r_n     = 1'b0;
        done_n  = 1'b0;
        err_n   = err;
        case (state)
            IDLE: begin
                // level is registered, so a push into an empty FIFO is only
                // seen here on the following cycle.
                if (level != '0) begin
                    pop   = 1'b1;
                    tgt_n = head;
                    if (head == q_fb) begin
                        done_n = 1'b1;
                    end else begin
                        s_n     = head;
                        r_n     = ~head;
                        pcnt_n  = '0;
                        state_n = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (pcnt == PW'(PULSE_CYC - 1)) begin
                    ccnt_n  = '0;
                    state_n = CHECK;
                end else begin
                    s_n    = s;
                    r_n    = r;
                    pcnt_n = pcnt + 1'b1;
                end
            end
            CHECK: begin
                if (q_fb == tgt) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (ccnt == TW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = ERR;
                end else begin
                    ccnt_n = ccnt + 1'b1;
                end
            end
            ERR: begin
                // The failed target is already popped; clearing drops it.
                if (clr_err) begin
                    err_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and registered outputs; reset aborts any pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tgt   <= 1'b0;
            pcnt  <= '0;
            ccnt  <= '0;
            s     <= 1'b0;
            r     <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            tgt   <= tgt_n;
            pcnt  <= pcnt_n;
            ccnt  <= ccnt_n;
            s     <= s_n;
            r     <= r_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

endmodule

// File: tb/tb_sr_ff_driver.sv
// Bench for sr_ff_driver: a default build driven through a queued
// scoreboard, plus a PULSE_CYC=3 / TIMEOUT=2 build for pulse-width timing.
module tb_sr_ff_driver;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- default build ----------------
    logic       in_valid = 1'b0, in_bit = 1'b0, clr_err = 1'b0;
    logic       in_ready, s, r, done, err, q_fb;
    logic [2:0] level;
    logic       q1 = 1'b0;
    logic       tie0 = 1'b0;
    logic [1:0] st1;

    assign q_fb = tie0 ? 1'b0 : q1;

    sr_ff_driver dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .q_fb(q_fb), .clr_err(clr_err),
        .s(s), .r(r), .done(done), .err(err), .level(level)
    );
    assign st1 = dut.state;

    // SR flop model: q follows s/r on the edge after they are driven.
    always @(posedge clk) begin
        if (s) q1 <= 1'b1;
        else if (r) q1 <= 1'b0;
    end

    // ---------------- PULSE_CYC=3, TIMEOUT=2 build ----------------
    logic       in_valid2 = 1'b0, in_bit2 = 1'b0;
    logic       clr_err2 = 1'b0;
    logic       in_ready2, s2, r2, done2, err2;
    logic [2:0] level2;
    logic       q2 = 1'b0;

    sr_ff_driver #(.DEPTH(4), .PULSE_CYC(3), .TIMEOUT(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_bit(in_bit2),
        .in_ready(in_ready2), .q_fb(q2), .clr_err(clr_err2),
        .s(s2), .r(r2), .done(done2), .err(err2), .level(level2)
    );

    always @(posedge clk) begin
        if (s2) q2 <= 1'b1;
        else if (r2) q2 <= 1'b0;
    end

    // ---------------- scoreboard ----------------
    int   checks = 0;
    int   failures = 0;
    logic [0:0] exp_q[$];
    int   done_cnt = 0;
    int   s_cyc = 0;
    int   r_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Monitor: retire one expected target per done pulse, check invariants.
    always @(negedge clk) begin
        if (!reset) begin
            check("s_and_r", int'(s & r), 0);
            check("done_and_err", int'(done & err), 0);
            check("s2_and_r2", int'(s2 & r2), 0);
            check("done2_and_err2", int'(done2 & err2), 0);
            if (s) s_cyc++;
            if (r) r_cyc++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("retired_q", int'(q_fb), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push1(input logic b, output logic acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        acc      = in_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(b);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (level == 3'd0 && st1 == ST_IDLE && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", int'(ok), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_err();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (err) begin
                ok = 1'b1;
                break;
            end
        end
        check("err_wait_timeout", int'(ok), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        int   d0, s0, r0, first_err, first_s, s_in_win;
        int   s2_mask, done2_at, done2_n;
        logic vals [5];
        logic b;

        // Reset state (outputs must already be at reset values)
        #1;
        check("rst_s", int'(s), 0);
        check("rst_r", int'(r), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_level", int'(level), 0);
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        reset = 1'b0;

        // Test 1: push 1,0,0 back-to-back with a well-behaved flop
        d0 = done_cnt; s0 = s_cyc; r0 = r_cyc;
        push1(1'b1, acc);
        push1(1'b0, acc);
        push1(1'b0, acc);
        drain();
        check("t1_done_count", done_cnt - d0, 3);
        check("t1_s_cycles", s_cyc - s0, 1);
        check("t1_r_cycles", r_cyc - r0, 1);
        check("t1_level", int'(level), 0);

        // clr_err outside ERR has no effect
        pulse_clr();
        @(negedge clk);
        check("clr_idle_state", int'(st1), int'(ST_IDLE));
        check("clr_idle_err", int'(err), 0);

        // Test 2: q_fb stuck low, push 1 -> timeout
        tie0 = 1'b1;
        push1(1'b1, acc);
        first_err = 0; first_s = 0; s_in_win = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (s) begin
                s_in_win++;
                if (first_s == 0) first_s = n;
            end
            if (err && first_err == 0) first_err = n;
        end
        check("t2_s_first", first_s, 2);
        check("t2_s_cycles", s_in_win, 1);
        check("t2_err_cycle", first_err, 7);
        check("t2_state_err", int'(st1), int'(ST_ERR));
        check("t2_s_low", int'(s), 0);
        check("t2_r_low", int'(r), 0);
        pulse_clr();
        void'(exp_q.pop_front());
        @(negedge clk);
        check("t2_err_cleared", int'(err), 0);
        check("t2_state_idle", int'(st1), int'(ST_IDLE));
        d0 = done_cnt;
        push1(1'b0, acc);
        drain();
        check("t2_hold_done", done_cnt - d0, 1);

        // Test 3: fill the FIFO while in ERR, fifth push dropped
        push1(1'b1, acc);
        wait_err();
        vals[0] = 1'b0; vals[1] = 1'b1; vals[2] = 1'b1; vals[3] = 1'b0;
        vals[4] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push1(vals[k-1], acc);
            if (k <= 4) begin
                check("t3_accept", int'(acc), 1);
                check("t3_level", int'(level), k);
            end else begin
                check("t3_fifth_dropped", int'(acc), 0);
                check("t3_level_full", int'(level), 4);
            end
        end
        check("t3_ready_full", int'(in_ready), 0);
        tie0 = 1'b0;
        d0 = done_cnt;
        pulse_clr();
        void'(exp_q.pop_front());
        drain();
        check("t3_retired", done_cnt - d0, 4);
        // Refill across the pointer wrap
        d0 = done_cnt;
        push1(1'b1, acc);
        push1(1'b0, acc);
        push1(1'b0, acc);
        push1(1'b1, acc);
        drain();
        check("t3_refill_retired", done_cnt - d0, 4);

        // Test 4: PULSE_CYC=3 build, push 1
        @(negedge clk);
        in_valid2 = 1'b1;
        in_bit2   = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        s2_mask = 0; done2_at = 0; done2_n = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (s2) s2_mask |= (1 << n);
            if (done2) begin
                done2_n++;
                if (done2_at == 0) done2_at = n;
            end
        end
        check("t4_s_window", s2_mask, 32'h1c);
        check("t4_done_at", done2_at, 6);
        check("t4_done_count", done2_n, 1);
        check("t4_err", int'(err2), 0);

        // Test 5: asynchronous reset mid-DRIVE
        b = ~q_fb;
        push1(b, acc);
        push1(b, acc);
        check("t5_in_drive", int'(s | r), 1);
        #2 reset = 1'b1;
        #1;
        check("t5_s_async", int'(s), 0);
        check("t5_r_async", int'(r), 0);
        check("t5_level_async", int'(level), 0);
        check("t5_err_async", int'(err), 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        push1(1'b0, acc);
        push1(1'b1, acc);
        drain();
        check("t5_resume_done", done_cnt - d0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "time limit");
    end

endmodule
